// File: rtl/adder_32.sv
// adder_32: WIDTH-bit carry-lookahead adder (4-bit groups) with combinational status flags
// and a one-cycle registered tap. Defining ADDER_SUB_EN adds a 'sub' port for a - b.
module adder_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic [WIDTH-1:0] y_q,
    output logic [3:0]       flags_q
);

    localparam int NGROUPS = WIDTH / 4;

    logic [WIDTH-1:0] bEff;
    logic             carryIn;

`ifdef ADDER_SUB_EN
    // Subtraction is a + ~b + 1; the external carry-in is ignored in that mode.
    assign bEff    = sub ? ~b : b;
    assign carryIn = sub ? 1'b1 : cin;
`else
    assign bEff    = b;
    assign carryIn = cin;
`endif

    logic [WIDTH-1:0] bitP;
    logic [WIDTH-1:0] bitG;
    logic [WIDTH:0]   bitC;
    logic [3:0]       grpP4;
    logic [3:0]       grpG4;
    logic             grpProp;
    logic             grpGen;
    logic             carry;

    assign bitP = a ^ bEff;
    assign bitG = a & bEff;

    // Lookahead inside each 4-bit group; the group carry then ripples to the next group.
    always_comb begin
        bitC    = '0;
        grpP4   = '0;
        grpG4   = '0;
        grpProp = 1'b0;
        grpGen  = 1'b0;
        carry   = carryIn;
        for (int i = 0; i < NGROUPS; i++) begin
            grpP4 = bitP[4*i +: 4];
            grpG4 = bitG[4*i +: 4];
            bitC[4*i]     = carry;
            bitC[4*i + 1] = grpG4[0] | (grpP4[0] & carry);
            bitC[4*i + 2] = grpG4[1] | (grpP4[1] & grpG4[0])
                          | (grpP4[1] & grpP4[0] & carry);
            bitC[4*i + 3] = grpG4[2] | (grpP4[2] & grpG4[1])
                          | (grpP4[2] & grpP4[1] & grpG4[0])
                          | (grpP4[2] & grpP4[1] & grpP4[0] & carry);
            grpGen  = grpG4[3] | (grpP4[3] & grpG4[2])
                    | (grpP4[3] & grpP4[2] & grpG4[1])
                    | (grpP4[3] & grpP4[2] & grpP4[1] & grpG4[0]);
            grpProp = &grpP4;
            carry   = grpGen | (grpProp & carry);
        end
        bitC[WIDTH] = carry;
    end

    assign y    = bitP ^ bitC[WIDTH-1:0];
    assign cout = bitC[WIDTH];
    assign ovf  = (a[WIDTH-1] == bEff[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
    assign zero = ~|y;
    assign neg  = y[WIDTH-1];

    logic [WIDTH-1:0] y_d;
    logic [3:0]       flags_d;

    assign y_d     = y;
    assign flags_d = {cout, ovf, zero, neg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            y_q     <= y_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_adder_32.sv
// tb_adder_32: directed and randomized checks of adder_32 against an arithmetic reference model.
// Build with ADDER_SUB_EN defined to also exercise the subtract mode.
module tb_adder_32;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] y;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
    logic [31:0] y_q;
    logic [3:0]  flags_q;

    int compared;
    int mismatched;

    adder_32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .cin     (cin),
`ifdef ADDER_SUB_EN
        .sub     (sub),
`endif
        .y       (y),
        .cout    (cout),
        .ovf     (ovf),
        .zero    (zero),
        .neg     (neg),
        .y_q     (y_q),
        .flags_q (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {y, cout, ovf, zero, neg} from plain 64-bit integer arithmetic.
    function automatic logic [35:0] refModel(input logic [31:0] ra, input logic [31:0] rb,
                                             input logic rc, input logic rs);
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned ures;
        longint          sa;
        longint          sb;
        longint          sres;
        logic [31:0]     ry;
        logic            rco;
        logic            rov;
        ua = ra;
        ub = rb;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        if (rs) begin
            ures = ua - ub;
            rco  = (ua >= ub);
            sres = sa - sb;
        end else begin
            ures = ua + ub + longint'(rc);
            rco  = (ures > 64'h0000_0000_FFFF_FFFF);
            sres = sa + sb + longint'(rc);
        end
        ry  = ures[31:0];
        rov = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        return {ry, rco, rov, (ry == 32'd0), ry[31]};
    endfunction

    task automatic test_reset();
        logic [35:0] exp;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(1));
            exp = refModel(a, b, cin, 1'b0);
            #1;
            compared++;
            if ({y, cout, ovf, zero, neg} !== exp) begin
                mismatched++;
                $display("[TB] FAIL comb_during_reset got=%h exp=%h", {y, cout, ovf, zero, neg}, exp);
            end
            @(posedge clk);
            #1;
            compared++;
            if ({y_q, flags_q} !== 36'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_hold got=%h exp=%h", {y_q, flags_q}, 36'd0);
            end
        end
    endtask

    task automatic test_flags();
        logic [31:0] va   [5];
        logic [31:0] vb   [5];
        logic        vc   [5];
        logic [35:0] vexp [5];
        va[0] = 32'h0000_0004; vb[0] = 32'h0000_0008; vc[0] = 1'b0; vexp[0] = {32'h0000_000C, 4'b0000};
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0001; vc[1] = 1'b0; vexp[1] = {32'h0000_0000, 4'b1010};
        va[2] = 32'h7FFF_FFFF; vb[2] = 32'h0000_0001; vc[2] = 1'b0; vexp[2] = {32'h8000_0000, 4'b0101};
        va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000; vc[3] = 1'b0; vexp[3] = {32'h0000_0000, 4'b1110};
        va[4] = 32'hFFFF_FFFF; vb[4] = 32'h0000_0000; vc[4] = 1'b1; vexp[4] = {32'h0000_0000, 4'b1010};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a   = va[i];
            b   = vb[i];
            cin = vc[i];
            sub = 1'b0;
            #1;
            compared++;
            if ({y, cout, ovf, zero, neg} !== vexp[i]) begin
                mismatched++;
                $display("[TB] FAIL flags_vec%0d got=%h exp=%h", i, {y, cout, ovf, zero, neg}, vexp[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        reset = 1'b0;
        a     = 32'h1234_5678;
        b     = 32'h1111_1111;
        cin   = 1'b0;
        sub   = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if ({y_q, flags_q} !== {32'h2345_6789, 4'b0000}) begin
            mismatched++;
            $display("[TB] FAIL reg_capture got=%h exp=%h", {y_q, flags_q}, {32'h2345_6789, 4'b0000});
        end
    endtask

    task automatic test_async_reset();
        // Mid-cycle assertion must clear the tap without any clock edge.
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if ({y_q, flags_q} !== 36'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset got=%h exp=%h", {y_q, flags_q}, 36'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0000_0001;
        @(posedge clk);
        #1;
        compared++;
        if ({y_q, flags_q} !== {32'h0000_0000, 4'b1010}) begin
            mismatched++;
            $display("[TB] FAIL reg_after_reset got=%h exp=%h", {y_q, flags_q}, {32'h0000_0000, 4'b1010});
        end
        @(negedge clk);
        a = 32'h0000_0003;
        b = 32'h0000_0004;
        @(posedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if ({y_q, flags_q} !== 36'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_at_edge got=%h exp=%h", {y_q, flags_q}, 36'd0);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

`ifdef ADDER_SUB_EN
    task automatic test_sub();
        @(negedge clk);
        a   = 32'h0000_0005;
        b   = 32'h0000_0007;
        cin = 1'b0;
        sub = 1'b1;
        #1;
        compared++;
        if ({y, cout, ovf, zero, neg} !== {32'hFFFF_FFFE, 4'b0001}) begin
            mismatched++;
            $display("[TB] FAIL sub_5_7 got=%h exp=%h", {y, cout, ovf, zero, neg}, {32'hFFFF_FFFE, 4'b0001});
        end
        @(negedge clk);
        a   = 32'h0000_0007;
        b   = 32'h0000_0005;
        cin = 1'b1;
        #1;
        compared++;
        if ({y, cout, ovf, zero, neg} !== {32'h0000_0002, 4'b1000}) begin
            mismatched++;
            $display("[TB] FAIL sub_7_5 got=%h exp=%h", {y, cout, ovf, zero, neg}, {32'h0000_0002, 4'b1000});
        end
        sub = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [35:0] exp;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h7FFF_FFFF;
        corner[3] = 32'h8000_0000;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            a   = ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : $urandom;
            b   = ($urandom_range(7) == 0) ? corner[$urandom_range(3)] : $urandom;
            cin = 1'($urandom_range(1));
`ifdef ADDER_SUB_EN
            sub = 1'($urandom_range(1));
`else
            sub = 1'b0;
`endif
            exp = refModel(a, b, cin, sub);
            #1;
            compared++;
            if ({y, cout, ovf, zero, neg} !== exp) begin
                mismatched++;
                $display("[TB] FAIL rand_comb a=%h b=%h cin=%b sub=%b got=%h exp=%h",
                         a, b, cin, sub, {y, cout, ovf, zero, neg}, exp);
            end
            @(posedge clk);
            #1;
            compared++;
            if ({y_q, flags_q} !== exp) begin
                mismatched++;
                $display("[TB] FAIL rand_reg a=%h b=%h got=%h exp=%h", a, b, {y_q, flags_q}, exp);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        a          = '0;
        b          = '0;
        cin        = 1'b0;
        sub        = 1'b0;
        test_reset();
        test_flags();
        test_registered();
        test_async_reset();
`ifdef ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/adder_32.md
Name: adder_32

Overview:
- WIDTH-bit two's-complement adder used as the datapath adder of the single-cycle processor (PC increment, branch target).
- Primary sum output y is purely combinational: y = a + b.
- Also produces combinational status flags and a one-cycle registered copy of sum and flags for debug/pipeline tap.
- Internally built as a carry-lookahead adder in 4-bit groups with group propagate/generate, not a behavioural "+".

Parameters:
- WIDTH, 32, operand and sum width; must be a multiple of 4, minimum 4.

Ports:
- clk  input  1  clock; rising edge updates registered outputs.
- reset  input  1  asynchronous, active-high reset of registered outputs only.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; tie 0 for plain a+b.
- y  output  WIDTH  combinational sum (a + b + cin) mod 2^WIDTH.
- cout  output  1  combinational carry out of MSB.
- ovf  output  1  combinational signed overflow: a[MSB]==b[MSB] and y[MSB]!=a[MSB].
- zero  output  1  combinational, 1 when y == 0.
- neg  output  1  combinational, equals y[MSB].
- y_q  output  WIDTH  y registered on rising clk.
- flags_q  output  4  {cout, ovf, zero, neg} registered on rising clk.

Behaviour:
- y, cout, ovf, zero, neg: zero latency, pure function of a, b, cin (and sub when enabled); independent of clk and reset, valid during reset.
- Arithmetic: full WIDTH+1-bit sum; y = low WIDTH bits, cout = bit WIDTH; wrap-around modulo 2^WIDTH, no saturation.
- CLA structure: per-bit p = a^b, g = a&b; 4-bit group lookahead; group carries chained ripple-style between groups; sum bit = p ^ carry-in of that bit.
- No X propagation beyond inputs: any X/Z input bit may produce X outputs; all-known inputs must give all-known outputs.
- Registered outputs: on reset assertion (asynchronous), y_q = 0 and flags_q = 4'b0000 immediately; held while reset high.
- Registered outputs: after reset deasserts, each rising clk captures current y into y_q and {cout,ovf,zero,neg} into flags_q; latency exactly 1 cycle.
- Reset asserted coincident with a clock edge: reset wins, registers stay 0.
- No handshake, no state machine, no enable: registers update every cycle.

Optional Feature:
- Macro ADDER_SUB_EN.
- Defined: extra input port sub (1 bit). When sub=1, the operand B path is inverted and the carry-in becomes 1, so y = a - b (a + ~b + 1, cin ignored). cout is then the no-borrow indicator (1 when a >= b unsigned). ovf uses the inverted-B MSB in its equation. When sub=0, behaviour is identical to the build without the macro.
- Not defined: no sub port; always y = a + b + cin.

Test Plan:
- a=0x00000004, b=0x00000008, cin=0 -> y=0x0000000C, cout=0, ovf=0, zero=0, neg=0 in the same cycle (checked before next clk edge).
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> y=0x00000000, cout=1, zero=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001 -> y=0x80000000, ovf=1, neg=1, cout=0.
- a=0x80000000, b=0x80000000 -> y=0x00000000, cout=1, ovf=1, zero=1.
- Registered path: hold reset=1 -> y_q=0, flags_q=0 regardless of a/b. Release reset, apply a=0x12345678, b=0x11111111 -> after next rising clk y_q=0x23456789, flags_q=4'b0000. Assert reset asynchronously mid-cycle -> y_q=0 without waiting for a clock edge.
- ADDER_SUB_EN build: sub=1, a=0x00000005, b=0x00000007 -> y=0xFFFFFFFE, cout=0, neg=1. Randomized sweep of 10,000 vectors: y must equal the reference a+b+cin modulo 2^32 (a−b when sub=1).
